// File: rtl/mult_hilo_unit.sv
// Iterative shift-add unsigned multiplier with architectural HI/LO registers.
// One iteration per cycle; the pipeline is stalled on HI/LO accesses while busy.
module mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             hi_sel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

  // acc_q[WIDTH] is always zero after a shift, so adding the full acc is
  // equivalent to adding its low WIDTH bits; the extra bit keeps the carry.
  assign addend = mplier_q[0] ? {1'b0, mcand_q} : '0;
  assign sum    = acc_q + addend;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      RUN: begin
        acc_d    = {1'b0, sum[WIDTH:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          hi_d    = sum[WIDTH:1];
          lo_d    = mplier_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign stall    = busy & (rd_req | start | wr_hi | wr_lo);
  assign hilo_out = hi_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed self-checking bench for mult_hilo_unit (WIDTH = 32).
// Inputs change and outputs are sampled around the falling clock edge.
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        rd_req, hi_sel, wr_hi, wr_lo;
  logic [31:0] wdata;
  logic [31:0] hilo_out;
  logic        busy, done, stall;

  int n_cmp = 0;
  int n_bad = 0;

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .rd_req   (rd_req),
    .hi_sel   (hi_sel),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .wdata    (wdata),
    .hilo_out (hilo_out),
    .busy     (busy),
    .done     (done),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  // Caller is at a falling edge. Issues start for one cycle, then waits for done.
  // lat counts cycles from the start edge to the done cycle; busy_cnt counts busy cycles.
  task automatic run_mul(input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int busy_cnt);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = '1; b = '1;
    rd_req = 1'b1; hi_sel = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (hilo_out !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hilo_out); end
    hi_sel = 1'b0; #1;
    n_cmp++; if (hilo_out !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", hilo_out); end
    start = 1'b0; rd_req = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0; a = '0; b = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small_product();
    int lat, bc;
    run_mul(32'd3, 32'd5, lat, bc);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL small_latency: got %0d want 32", lat); end
    n_cmp++; if (bc !== 32) begin n_bad++; $display("FAIL small_busy_cycles: got %0d want 32", bc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL small_busy_at_done: got %b want 0", busy); end
    hi_sel = 1'b1; #1;
    n_cmp++; if (hilo_out !== 32'h0) begin n_bad++; $display("FAIL small_hi: got %h want 00000000", hilo_out); end
    hi_sel = 1'b0; #1;
    n_cmp++; if (hilo_out !== 32'hF) begin n_bad++; $display("FAIL small_lo: got %h want 0000000f", hilo_out); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL small_done_width: got %b want 0", done); end
  endtask

  // Second multiply issued in the done cycle of the first: back-to-back every 33 cycles.
  task automatic test_max_back_to_back();
    int lat, bc;
    @(negedge clk);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL max_latency: got %0d want 32", lat); end
    hi_sel = 1'b1; #1;
    n_cmp++; if (hilo_out !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL max_hi: got %h want fffffffe", hilo_out); end
    hi_sel = 1'b0; #1;
    n_cmp++; if (hilo_out !== 32'h1) begin n_bad++; $display("FAIL max_lo: got %h want 00000001", hilo_out); end
    run_mul(32'h8000_0000, 32'd2, lat, bc);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL b2b_latency: got %0d want 32", lat); end
    n_cmp++; if (bc !== 32) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 32", bc); end
    hi_sel = 1'b1; #1;
    n_cmp++; if (hilo_out !== 32'h1) begin n_bad++; $display("FAIL msb_hi: got %h want 00000001", hilo_out); end
    hi_sel = 1'b0; #1;
    n_cmp++; if (hilo_out !== 32'h0) begin n_bad++; $display("FAIL msb_lo: got %h want 00000000", hilo_out); end
  endtask

  task automatic test_stall();
    logic exp_stall;
    @(negedge clk);
    start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k == 5) begin rd_req = 1'b1; hi_sel = 1'b1; end
      #1;
      exp_stall = (k >= 5 && k < 32);
      n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL stall_k%0d: got %b want %b", k, stall, exp_stall); end
      if (k == 32) begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done_k32: got %b want 1", done); end
      end
      if (k >= 32) begin
        n_cmp++; if (hilo_out !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL stall_read_hi_k%0d: got %h want fffffffe", k, hilo_out); end
      end
      @(negedge clk);
    end
    rd_req = 1'b0; hi_sel = 1'b0;
  endtask

  task automatic test_ignored_while_busy();
    int k;
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      if (k == 10) begin start = 1'b1; a = 32'd7; b = 32'd9; end
      if (k == 15) begin wr_lo = 1'b1; wdata = 32'h0000_DEAD; end
      #1;
      if (k == 10) begin
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ign_start_stall: got %b want 1", stall); end
      end
      if (k == 15) begin
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ign_wrlo_stall: got %b want 1", stall); end
      end
      @(negedge clk);
      start = 1'b0; wr_lo = 1'b0;
      k++;
    end
    n_cmp++; if (k !== 32) begin n_bad++; $display("FAIL ign_latency: got %0d want 32", k); end
    hi_sel = 1'b0; #1;
    n_cmp++; if (hilo_out !== 32'd15) begin n_bad++; $display("FAIL ign_lo: got %h want 0000000f", hilo_out); end
    hi_sel = 1'b1; #1;
    n_cmp++; if (hilo_out !== 32'h0) begin n_bad++; $display("FAIL ign_hi: got %h want 00000000", hilo_out); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_no_restart: got busy %b want 0", busy); end
    wr_hi = 1'b1; wdata = 32'h0000_1234; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL idle_wr_stall: got %b want 0", stall); end
    @(negedge clk);
    wr_hi = 1'b0; wdata = '0; hi_sel = 1'b1; #1;
    n_cmp++; if (hilo_out !== 32'h0000_1234) begin n_bad++; $display("FAIL idle_wrhi: got %h want 00001234", hilo_out); end
    hi_sel = 1'b0; #1;
    n_cmp++; if (hilo_out !== 32'd15) begin n_bad++; $display("FAIL idle_wrhi_lo_kept: got %h want 0000000f", hilo_out); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    @(negedge clk);
    start = 1'b1; a = 32'hFFFF_FFFF; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rd_req = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_stall: got %b want 1", stall); end
    rst = 1'b1; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    hi_sel = 1'b1; #1;
    n_cmp++; if (hilo_out !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi: got %h want 0", hilo_out); end
    hi_sel = 1'b0; #1;
    n_cmp++; if (hilo_out !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo: got %h want 0", hilo_out); end
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_mul(32'd6, 32'd7, lat, bc);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL post_rst_latency: got %0d want 32", lat); end
    hi_sel = 1'b0; #1;
    n_cmp++; if (hilo_out !== 32'd42) begin n_bad++; $display("FAIL post_rst_lo: got %h want 0000002a", hilo_out); end
    hi_sel = 1'b1; #1;
    n_cmp++; if (hilo_out !== 32'h0) begin n_bad++; $display("FAIL post_rst_hi: got %h want 00000000", hilo_out); end
    hi_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_small_product();
    test_max_back_to_back();
    test_stall();
    test_ignored_while_busy();
    test_reset_mid();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
# mult_hilo_unit

Iterative unsigned multiplier with architectural HI/LO registers for the pipelined MIPS core. It sits in the EX stage downstream of the control unit. It is started by the decoded HILO write-enable (multu), and its HI/LO read port feeds the writeback-select mux for mfhi/mflo. While a multiply is in flight, it raises a stall to the hazard logic, so dependent HI/LO accesses wait for the result.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin multiply of a × b (driven by HILO_we of the EX-stage instruction)
- a  in  WIDTH  multiplicand (rs value)
- b  in  WIDTH  multiplier (rt value)
- rd_req  in  1  EX instruction reads HI/LO (mfhi/mflo)
- hi_sel  in  1  1 = read HI, 0 = read LO (HI_LO_mux_en)
- wr_hi  in  1  direct write of HI (mthi)
- wr_lo  in  1  direct write of LO (mtlo)
- wdata  in  WIDTH  data for wr_hi/wr_lo
- hilo_out  out  WIDTH  combinational read: hi_sel ? HI : LO
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse: HI/LO just loaded with a product
- stall  out  1  freeze IF/ID/EX: busy & (rd_req | start | wr_hi | wr_lo)

## Operation
- **States.**
  - IDLE: busy = 0. Accepts start, wr_hi and wr_lo.
  - RUN: busy = 1. Performs WIDTH shift-add iterations.
- **IDLE, start = 1:**
  - Latch mcand = a and mplier = b.
  - Clear acc (WIDTH+1 bits, to keep the carry) and count.
  - Go to RUN.
- **IDLE, start together with wr_hi or wr_lo:** start wins; the direct write is dropped.
- **IDLE, wr_hi = 1:** HI ← wdata.
- **IDLE, wr_lo = 1:** LO ← wdata. wr_hi and wr_lo may be asserted together.
- **RUN iteration (one per cycle):**
  - sum = acc[WIDTH-1:0] + (mplier[0] ? mcand : 0), computed WIDTH+1 bits wide.
  - {acc, mplier} ← {sum, mplier} >> 1 (logical).
  - count ← count + 1.
- **Final iteration (count = WIDTH-1):**
  - HI ← new acc[WIDTH-1:0]; LO ← new mplier.
  - done ← 1; go to IDLE.
- **Product is unsigned:** {HI, LO} = a × b, exactly 2·WIDTH bits, no overflow possible.
- **Requests during RUN:**
  - start, wr_hi and wr_lo are ignored; state and HI/LO are unchanged.
  - stall is asserted so the pipeline holds the instruction until busy falls.
- **hilo_out** always reflects the current HI/LO registers. During RUN it shows the previous values; stall guarantees they are not consumed.
- **Reset (asynchronous, any time, including mid-RUN):**
  - State → IDLE.
  - HI, LO, acc, mplier, mcand and count → 0.
  - busy, done, stall → 0; hilo_out → 0.
  - A multiply in flight is abandoned.

## Timing
- Edge E0 samples start = 1 in IDLE; busy is high from just after E0.
- Iterations occur on edges E1..E_WIDTH.
- At E_WIDTH:
  - HI/LO are loaded and busy falls.
  - done is high for exactly the cycle between E_WIDTH and E_WIDTH+1.
- Latency is WIDTH cycles from the start edge to the result being visible on hilo_out (32 for the default WIDTH).
- A new start is accepted at E_WIDTH+1, i.e. back-to-back multiplies every WIDTH+1 cycles.
- stall is combinational from busy and the request inputs: it is same-cycle and has no registered delay.
- A direct write in IDLE updates HI/LO at that edge; hilo_out shows the new value in the next cycle.

## Test plan
- **Small product:** start with a = 3, b = 5 → busy high for 32 cycles, then one done pulse; HI = 0x00000000, LO = 0x0000000F.
- **Maximum operands:** a = b = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Also a = 0x80000000, b = 2 → HI = 1, LO = 0.
- **Stall during RUN:** rd_req = 1 with hi_sel = 1 in cycles 5..40 after start → stall = 1 through the cycle before done, 0 from the done cycle. hilo_out then shows the new HI.
- **Requests ignored while busy:**
  - start with a = 7, b = 9 issued mid-RUN of 3 × 5 → ignored; the result is LO = 15.
  - wr_lo with wdata = 0xDEAD mid-RUN → ignored; LO = 15.
  - Then, in IDLE, wr_hi with wdata = 0x1234 → HI = 0x1234 next cycle.
- **Reset mid-multiply:** assert rst at cycle 10 of a 0xFFFFFFFF × 2 multiply → busy, done and stall drop immediately; HI = LO = 0. After release, a = 6, b = 7 produces LO = 42 with the normal 32-cycle latency.
